fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch byte address.
REQ-002 SHALL have parameter IMEM_BYTES, default 24, meaning the instruction-memory size in bytes; a fetch address at or above IMEM_BYTES-3 is out of range.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  in  1  hazard request to hold IF and IF/ID.
REQ-006 SHALL have port br_taken  in  1  redirect request from the resolving stage.
REQ-007 SHALL have port br_target  in  32  redirect byte address.
REQ-008 SHALL have port imem_in  in  32  instruction word returned combinationally by instruction memory for pc.
REQ-009 SHALL have port pc  out  32  fetch byte address driven to instruction memory.
REQ-010 SHALL have port EnIW  out  1  instruction-memory read enable.
REQ-011 SHALL have port if_id_instr  out  32  registered fetched instruction.
REQ-012 SHALL have port if_id_pc4  out  32  registered pc+4 of that instruction.
REQ-013 SHALL have port if_id_valid  out  1  high when if_id_instr holds a live instruction.
REQ-014 SHALL have port halted  out  1  high in state DONE.

Function
REQ-015 SHALL implement states BOOT, RUN, HOLD and DONE, held in a 2-bit state register.
REQ-016 BOOT SHALL last exactly one cycle after reset release, drive EnIW=0, and go to RUN.
REQ-017 In RUN, EnIW SHALL be 1, and on each edge IF/ID SHALL capture {imem_in, pc+4}, with if_id_valid=1, and pc SHALL advance by 4.
REQ-018 Priority SHALL be br_taken > stall > sequential, evaluated in RUN and HOLD.
REQ-019 On br_taken, pc SHALL load br_target, IF/ID SHALL be cleared (if_id_instr=0, if_id_valid=0), state SHALL be RUN, and any pending stall SHALL be ignored.
REQ-020 On stall without br_taken, pc, IF/ID and EnIW SHALL hold their values and the state SHALL be HOLD; HOLD SHALL return to RUN in the first cycle with stall=0.
REQ-021 br_target SHALL be forced to word alignment (bits [1:0] cleared) before it is loaded.
REQ-022 pc+4 SHALL wrap modulo 2^32 with no carry flag.
REQ-023 If the next pc would be out of range (REQ-002) and br_taken=0, the state SHALL go to DONE, EnIW=0, and if_id_valid=0 from the following edge.
REQ-024 DONE SHALL be left only on br_taken to an in-range target (go to RUN) or on reset.
REQ-025 A stall and an out-of-range next pc in the same cycle SHALL resolve to HOLD; the range check SHALL re-occur on leaving HOLD.

Reset
REQ-026 While rst=0, with no dependency on clk: pc=RESET_PC, state=BOOT, EnIW=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0.
REQ-027 Reset asserted mid-operation, including mid-HOLD or in DONE, SHALL discard all state; no partial instruction SHALL survive.

Configuration
REQ-028 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs fetch_cnt[31:0] (RUN cycles that capture) and stall_cnt[31:0] (HOLD cycles); both SHALL be reset to 0, saturate at all-ones, and not be cleared by br_taken.
REQ-029 Without FETCH_PERF_CNT_EN, these ports and counters SHALL be absent, with otherwise identical behaviour.

Structure
REQ-030 The state encoding (BOOT=0, RUN=1, HOLD=2, DONE=3), the NOP word 32'h0 and the instruction width of 32 SHALL be defined in the shared package mips_pkg.
REQ-031 The IF/ID capture/clear/hold register SHALL be the sub-module if_id_reg; the FSM and pc logic SHALL stay in fetch_ctrl.

Verification
REQ-032 Reset release -> one BOOT cycle with EnIW=0, then pc sequence 0,4,8,12,16, with if_id_pc4 following one edge later.
REQ-033 stall=1 for 3 cycles at pc=8 -> pc stays at 8 and IF/ID is unchanged for 3 edges, then resumes at 12.
REQ-034 br_taken=1 and stall=1 together with br_target=32'h6 -> pc=4, if_id_valid=0 on the next edge, state RUN.
REQ-035 Free-run with IMEM_BYTES=24 -> after the word at pc=16 is fetched, DONE is entered, halted=1 and EnIW=0; then br_taken to 0 -> RUN at pc=0.
REQ-036 rst dropped mid-HOLD, asynchronously between edges -> all outputs reach reset values immediately, and BOOT follows release.
REQ-037 With FETCH_PERF_CNT_EN, 5 fetches and 2 stall cycles -> fetch_cnt=5 and stall_cnt=2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM state encoding, IF/ID payload and control commands.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD    = 2'd0,
        IFID_CAPTURE = 2'd1,
        IFID_CLEAR   = 2'd2
    } ifid_cmd_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc4;
    } if_id_t;

    // A word fetch is legal only when its first byte lies below the limit.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W-1:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures, clears to a NOP bubble, or holds on command.
module if_id_reg
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  ifid_cmd_e cmd,
    input  if_id_t    data_in,
    output if_id_t    data_out,
    output logic      valid
);

    if_id_t data_q, data_d;
    logic   valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        case (cmd)
            IFID_CAPTURE: begin
                data_d  = data_in;
                valid_d = 1'b1;
            end
            IFID_CLEAR: begin
                data_d  = '{instr: NOP_WORD, pc4: 32'h0000_0000};
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '{instr: NOP_WORD, pc4: 32'h0000_0000};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: pc sequencing, redirect/stall handling, end-of-memory halt.
// Optional perf counters (fetch_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] imem_in,
    output logic [31:0] pc,
    output logic        EnIW,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(IMEM_BYTES - 3);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              en_iw_q, en_iw_d;
    logic              halted_q, halted_d;
    ifid_cmd_e         ifid_cmd;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] tgt_aligned;
    if_id_t            ifid_in, ifid_out;

    assign pc_plus4    = pc_q + 32'd4;
    assign tgt_aligned = br_target & 32'hFFFF_FFFC;

    // Next state, next pc and IF/ID command; redirect beats stall beats sequential fetch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ifid_cmd = IFID_HOLD;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, HOLD: begin
                if (br_taken) begin
                    pc_d     = tgt_aligned;
                    ifid_cmd = IFID_CLEAR;
                    state_d  = RUN;
                end else if (stall) begin
                    state_d = HOLD;
                end else if (!addr_in_range(pc_plus4, PC_LIMIT)) begin
                    ifid_cmd = IFID_CLEAR;
                    state_d  = DONE;
                end else begin
                    pc_d     = pc_plus4;
                    ifid_cmd = IFID_CAPTURE;
                    state_d  = RUN;
                end
            end
            DONE: begin
                if (br_taken && addr_in_range(tgt_aligned, PC_LIMIT)) begin
                    pc_d     = tgt_aligned;
                    ifid_cmd = IFID_CLEAR;
                    state_d  = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        en_iw_d  = (state_d == RUN) || (state_d == HOLD);
        halted_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            en_iw_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            en_iw_q  <= en_iw_d;
            halted_q <= halted_d;
        end
    end

    assign ifid_in = '{instr: imem_in, pc4: pc_plus4};

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst),
        .cmd     (ifid_cmd),
        .data_in (ifid_in),
        .data_out(ifid_out),
        .valid   (if_id_valid)
    );

    assign pc          = pc_q;
    assign EnIW        = en_iw_q;
    assign halted      = halted_q;
    assign if_id_instr = ifid_out.instr;
    assign if_id_pc4   = ifid_out.pc4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters of capture edges and cycles spent in HOLD; redirects leave them alone.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (ifid_cmd == IFID_CAPTURE && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (state_q == HOLD && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
